// File: rtl/bcd_count_sequencer_if.sv
// ---------------------------------------------------------------------------------------------
// bcd_count_sequencer_if
//   Bundles the sequencer's button, terminal-value and counter-chain signals.
//   slave  : the sequencer itself (consumes buttons/qdata, drives chain controls and status).
//   master : the surrounding board logic / counter chain (drives buttons, term_bcd, qdata).
//
//   start      1   begin / resume counting
//   stop       1   pause in RUN, abort in PAUSE
//   term_bcd   16  terminal value, 4 BCD nibbles, [15:12] = thousands
//   qdata      16  current BCD value from the counter chain
//   cnt_ena    1   one-cycle increment pulse to the chain
//   cnt_clr    1   synchronous clear to the chain
//   led_blink  4   digit-match indicator / flash output
//   done       1   one-cycle pulse when the terminal value is reached
//   state      3   IDLE=0 RUN=1 PAUSE=2 HOLD=3 CLEAR=4
// ---------------------------------------------------------------------------------------------
interface bcd_count_sequencer_if;
  logic        start;
  logic        stop;
  logic [15:0] term_bcd;
  logic [15:0] qdata;
  logic        cnt_ena;
  logic        cnt_clr;
  logic [3:0]  led_blink;
  logic        done;
  logic [2:0]  state;

  modport slave (
    input  start,
    input  stop,
    input  term_bcd,
    input  qdata,
    output cnt_ena,
    output cnt_clr,
    output led_blink,
    output done,
    output state
  );

  modport master (
    output start,
    output stop,
    output term_bcd,
    output qdata,
    input  cnt_ena,
    input  cnt_clr,
    input  led_blink,
    input  done,
    input  state
  );
endinterface

// File: rtl/bcd_count_sequencer.sv
// ---------------------------------------------------------------------------------------------
// bcd_count_sequencer
//   Run/pause/stop sequencer for a 4-digit BCD counter chain. Divides clk into a count tick,
//   pulses the chain's increment enable once per tick while running, clears the chain on
//   start/abort/completion, and flashes the digit LEDs for HOLD_TICKS ticks once the chain
//   reaches the latched terminal value.
//
// Parameters
//   TICK_DIV    clk cycles per count tick (>= 2)
//   HOLD_TICKS  ticks spent flashing in HOLD before clearing (>= 1)
//
// Ports
//   clk     system clock, all logic on posedge
//   rst     synchronous, active-low reset
//   bus_io  slave side of bcd_count_sequencer_if (buttons, terminal value, chain
//           feedback in; cnt_ena / cnt_clr / led_blink / done / state out, all registered)
//
// Build option
//   BCD_SEQ_AUTO_RESTART_EN  when defined, leaving HOLD restarts counting from 0000 and
//                            stop is honoured in HOLD; when undefined, HOLD returns to IDLE
//                            and ignores stop.
// ---------------------------------------------------------------------------------------------
module bcd_count_sequencer #(
  parameter int unsigned TICK_DIV   = 50_000_000,
  parameter int unsigned HOLD_TICKS = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  bcd_count_sequencer_if.slave        bus_io
);

  localparam int unsigned PrescW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned HoldW  = $clog2(HOLD_TICKS + 1);

  localparam logic [PrescW-1:0] PrescMax = PrescW'(TICK_DIV - 1);
  localparam logic [HoldW-1:0]  HoldLast = HoldW'(HOLD_TICKS - 1);

  localparam logic [15:0] TermDefault = 16'h9999;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StRun   = 3'd1;
  localparam logic [2:0] StPause = 3'd2;
  localparam logic [2:0] StHold  = 3'd3;
  localparam logic [2:0] StClear = 3'd4;

`ifdef BCD_SEQ_AUTO_RESTART_EN
  localparam logic AutoRestart = 1'b1;
`else
  localparam logic AutoRestart = 1'b0;
`endif

  logic [2:0]        state_q,     state_d;
  logic [PrescW-1:0] presc_q,     presc_d;
  logic [HoldW-1:0]  hold_q,      hold_d;
  logic              phase_q,     phase_d;
  logic [15:0]       term_q,      term_d;
  logic              go_q,        go_d;
  logic              cnt_ena_q,   cnt_ena_d;
  logic              cnt_clr_q,   cnt_clr_d;
  logic [3:0]        led_blink_q, led_blink_d;
  logic              done_q,      done_d;

  logic              tick;
  logic              at_term;
  logic [PrescW-1:0] presc_adv;
  logic [3:0]        digit_match;

  // A terminal value with any nibble above 9 can never be reached by a BCD chain.
  function automatic logic is_bcd(input logic [15:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  assign tick      = (presc_q == PrescMax);
  assign presc_adv = tick ? '0 : presc_q + PrescW'(1);
  assign at_term   = (bus_io.qdata == term_q);

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    hold_d    = hold_q;
    phase_d   = phase_q;
    term_d    = term_q;
    go_d      = go_q;
    cnt_ena_d = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      StIdle: begin
        presc_d = '0;
        hold_d  = '0;
        if (bus_io.start) begin
          state_d = StClear;
          go_d    = 1'b1;
          term_d  = is_bcd(bus_io.term_bcd) ? bus_io.term_bcd : TermDefault;
        end
      end

      StClear: begin
        presc_d = '0;
        hold_d  = '0;
        go_d    = 1'b0;
        state_d = go_q ? StRun : StIdle;
      end

      StRun: begin
        presc_d = presc_adv;
        if (bus_io.stop) begin
          // Any tick landing on this cycle is dropped.
          state_d = StPause;
        end else if (at_term && !cnt_ena_q) begin
          // cnt_ena_q high means qdata is stale this cycle; wait for the chain to settle.
          state_d = StHold;
          done_d  = 1'b1;
          hold_d  = '0;
          phase_d = 1'b1;
        end else if (tick && !at_term) begin
          cnt_ena_d = 1'b1;
        end
      end

      StPause: begin
        // Prescaler left untouched so a resume finishes the interrupted tick period.
        if (bus_io.stop) begin
          state_d = StClear;
          go_d    = 1'b0;
        end else if (bus_io.start) begin
          state_d = StRun;
        end
      end

      StHold: begin
        presc_d = presc_adv;
        if (AutoRestart && bus_io.stop) begin
          state_d = StClear;
          go_d    = 1'b0;
        end else if (tick) begin
          phase_d = ~phase_q;
          if (hold_q == HoldLast) begin
            state_d = StClear;
            go_d    = AutoRestart;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + HoldW'(1);
          end
        end
      end

      default: begin
        state_d = StIdle;
        presc_d = '0;
        hold_d  = '0;
        go_d    = 1'b0;
      end
    endcase
  end

  // Registered outputs are computed from the next state so they line up with state_q.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      digit_match[i] = (bus_io.qdata[4*i +: 4] == term_d[4*i +: 4]);
    end

    cnt_clr_d = (state_d == StClear);

    case (state_d)
      StHold:         led_blink_d = {4{phase_d}};
      StRun, StPause: led_blink_d = digit_match;
      default:        led_blink_d = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      presc_q     <= '0;
      hold_q      <= '0;
      phase_q     <= 1'b0;
      term_q      <= TermDefault;
      go_q        <= 1'b0;
      cnt_ena_q   <= 1'b0;
      cnt_clr_q   <= 1'b0;
      led_blink_q <= 4'b0000;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      hold_q      <= hold_d;
      phase_q     <= phase_d;
      term_q      <= term_d;
      go_q        <= go_d;
      cnt_ena_q   <= cnt_ena_d;
      cnt_clr_q   <= cnt_clr_d;
      led_blink_q <= led_blink_d;
      done_q      <= done_d;
    end
  end

  assign bus_io.cnt_ena   = cnt_ena_q;
  assign bus_io.cnt_clr   = cnt_clr_q;
  assign bus_io.led_blink = led_blink_q;
  assign bus_io.done      = done_q;
  assign bus_io.state     = state_q;

endmodule

// File: tb/tb_bcd_count_sequencer.sv
// ---------------------------------------------------------------------------------------------
// tb_bcd_count_sequencer
//   Directed bench for bcd_count_sequencer with TICK_DIV=4, HOLD_TICKS=3. A behavioural BCD
//   counter chain closes the loop on cnt_ena / cnt_clr. Inputs change and outputs are sampled
//   on the falling clock edge.
// ---------------------------------------------------------------------------------------------
module tb_bcd_count_sequencer;

  logic clk;
  logic rst;

  bcd_count_sequencer_if bus ();

  bcd_count_sequencer #(
    .TICK_DIV   (4),
    .HOLD_TICKS (3)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Event counters on the DUT's chain controls, plus tick-spacing watch.
  int ena_cnt  = 0;
  int clr_cnt  = 0;
  int done_cnt = 0;
  int gap_bad  = 0;
  int cyc      = 0;
  int last_ena = 0;
  bit ena_seen = 1'b0;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Counter chain model: clear wins over increment, both sampled at the clock edge.
  initial bus.qdata = 16'h0000;
  always @(posedge clk) begin
    if (bus.cnt_clr)      bus.qdata <= 16'h0000;
    else if (bus.cnt_ena) bus.qdata <= bcd_inc(bus.qdata);
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.cnt_ena) begin
      ena_cnt <= ena_cnt + 1;
      if (ena_seen && (cyc - last_ena != 4)) gap_bad <= gap_bad + 1;
      last_ena <= cyc;
      ena_seen <= 1'b1;
    end
    if (bus.cnt_clr) clr_cnt  <= clr_cnt + 1;
    if (bus.done)    done_cnt <= done_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
    int n;
    n = 0;
    while (bus.state !== s && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_val(tag, 32'(bus.state), 32'(s));
  endtask

  task automatic wait_qdata(input logic [15:0] v, input int budget, input string tag);
    int n;
    n = 0;
    while (bus.qdata !== v && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_val(tag, 32'(bus.qdata), 32'(v));
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  int         ena_base;
  int         clr_base;
  int         done_base;
  int         gap_base;
  int         nchg;
  int         n;
  int         laps;
  logic [3:0] prev_led;
  logic [3:0] seq0;
  logic [3:0] seq1;

  initial begin
    bus.start    = 1'b1;
    bus.stop     = 1'b0;
    bus.term_bcd = 16'h0000;
    rst          = 1'b0;

    // 1: reset held with start asserted.
    @(negedge clk);
    @(negedge clk);
    check_val("rst_state", 32'(bus.state), 32'd0);
    check_val("rst_outs", {26'd0, bus.cnt_ena, bus.cnt_clr, bus.led_blink},
              32'd0);
    check_val("rst_done", 32'(bus.done), 32'd0);
    bus.start = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    check_val("rst_no_clr", 32'(clr_cnt), 32'd0);
    check_val("rst_idle", 32'(bus.state), 32'd0);

    // 2: count to 0012.
    bus.term_bcd = 16'h0012;
    ena_base     = ena_cnt;
    done_base    = done_cnt;
    gap_base     = gap_bad;
    pulse_start();
    check_val("clr_state", 32'(bus.state), 32'd4);
    check_val("clr_pulse", 32'(bus.cnt_clr), 32'd1);
    @(negedge clk);
    check_val("run_state", 32'(bus.state), 32'd1);
    check_val("clr_width", 32'(bus.cnt_clr), 32'd0);
    wait_state(3'd3, 200, "reach_hold");
    check_val("ena_total", 32'(ena_cnt - ena_base), 32'd12);
    check_val("tick_gap", 32'(gap_bad - gap_base), 32'd0);
    check_val("done_pulse", 32'(bus.done), 32'd1);
    check_val("term_q", 32'(bus.qdata), 32'h0012);
    check_val("hold_led0", 32'(bus.led_blink), 32'hF);
    @(negedge clk);
    check_val("done_once", 32'(done_cnt - done_base), 32'd1);
    check_val("done_width", 32'(bus.done), 32'd0);

    // 3: HOLD flash sequence then clear.
    prev_led = bus.led_blink;
    nchg     = 0;
    seq0     = 4'hx;
    seq1     = 4'hx;
    for (int i = 0; i < 60; i++) begin
      if (bus.state !== 3'd3) break;
      if (bus.led_blink !== prev_led) begin
        if (nchg == 0) seq0 = bus.led_blink;
        if (nchg == 1) seq1 = bus.led_blink;
        nchg++;
        prev_led = bus.led_blink;
      end
      @(negedge clk);
    end
    check_val("flash_chg", 32'(nchg), 32'd2);
    check_val("flash_1", 32'(seq0), 32'h0);
    check_val("flash_2", 32'(seq1), 32'hF);
    check_val("hold_exit", 32'(bus.state), 32'd4);
    check_val("hold_clr", 32'(bus.cnt_clr), 32'd1);
    @(negedge clk);
    check_val("chain_zero", 32'(bus.qdata), 32'h0000);
`ifdef BCD_SEQ_AUTO_RESTART_EN
    check_val("restart_run", 32'(bus.state), 32'd1);
    bus.stop = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.stop = 1'b0;
    wait_state(3'd0, 5, "abort_idle");
`else
    check_val("back_idle", 32'(bus.state), 32'd0);
`endif

    // 4: pause at 0005, resume, then abort with start+stop together.
    bus.term_bcd = 16'h0012;
    done_base    = done_cnt;
    pulse_start();
    wait_qdata(16'h0005, 200, "reach_5");
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    check_val("pause_state", 32'(bus.state), 32'd2);
    ena_base = ena_cnt;
    repeat (20) @(negedge clk);
    check_val("pause_no_ena", 32'(ena_cnt - ena_base), 32'd0);
    check_val("pause_hold", 32'(bus.state), 32'd2);
    check_val("pause_led", 32'(bus.led_blink), 32'hC);
    bus.start = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      n++;
      if (bus.cnt_ena) break;
    end
    check_val("resume_lat", 32'(n), 32'd3);
    check_val("resume_run", 32'(bus.state), 32'd1);
    bus.stop = 1'b1;
    @(negedge clk);
    check_val("pause2", 32'(bus.state), 32'd2);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    check_val("stop_wins", 32'(bus.state), 32'd4);
    @(negedge clk);
    check_val("abort_idle2", 32'(bus.state), 32'd0);
    check_val("abort_zero", 32'(bus.qdata), 32'h0000);
    check_val("abort_nodone", 32'(done_cnt - done_base), 32'd0);

    // 5a: non-BCD terminal falls back to 9999 (no digit matches near zero).
    bus.term_bcd = 16'h00A3;
    pulse_start();
    wait_qdata(16'h0003, 200, "reach_3");
    @(negedge clk);
    check_val("bad_term_led", 32'(bus.led_blink), 32'h0);
    check_val("bad_term_run", 32'(bus.state), 32'd1);
    bus.stop = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.stop = 1'b0;
    wait_state(3'd0, 5, "abort_idle3");

    // 5b: terminal 0000 goes straight to HOLD with no increments.
    bus.term_bcd = 16'h0000;
    ena_base     = ena_cnt;
    pulse_start();
    wait_state(3'd3, 20, "zero_hold");
    check_val("zero_no_ena", 32'(ena_cnt - ena_base), 32'd0);
    check_val("zero_done", 32'(bus.done), 32'd1);
    bus.stop = 1'b1;
`ifdef BCD_SEQ_AUTO_RESTART_EN
    wait_state(3'd0, 100, "hold_stop");
    bus.stop = 1'b0;
`else
    @(negedge clk);
    bus.stop = 1'b0;
    check_val("hold_ign_stop", 32'(bus.state), 32'd3);
    wait_state(3'd0, 100, "zero_idle");
`endif

`ifdef BCD_SEQ_AUTO_RESTART_EN
    // 6: auto-restart laps with terminal 0003.
    bus.term_bcd = 16'h0003;
    ena_base     = ena_cnt;
    clr_base     = clr_cnt;
    laps         = 0;
    pulse_start();
    for (int i = 0; i < 400; i++) begin
      if (bus.done) laps++;
      if (laps == 3) break;
      @(negedge clk);
    end
    check_val("laps", 32'(laps), 32'd3);
    check_val("lap_ena", 32'(ena_cnt - ena_base), 32'd9);
    check_val("lap_clr", 32'(clr_cnt - clr_base), 32'd3);
    bus.stop = 1'b1;
    wait_state(3'd0, 100, "lap_stop");
    bus.stop = 1'b0;
`endif

    // Reset mid-run: back to reset values, no clear pulse.
    bus.term_bcd = 16'h0012;
    pulse_start();
    repeat (10) @(negedge clk);
    check_val("pre_rst_run", 32'(bus.state), 32'd1);
    clr_base = clr_cnt;
    rst      = 1'b0;
    @(negedge clk);
    check_val("mid_rst_state", 32'(bus.state), 32'd0);
    check_val("mid_rst_outs", {27'd0, bus.cnt_ena, bus.led_blink}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check_val("mid_rst_noclr", 32'(clr_cnt - clr_base), 32'd0);
    check_val("mid_rst_idle", 32'(bus.state), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
